// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipeline skid register: state encoding and occupancy helper.
package pipe_pkg;

  // Encoding equals the number of held entries, so occupancy is a plain cast.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  function automatic logic [1:0] occ_of(input state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Handshake, control and status bundle for pipe_skid_reg.
interface pipe_skid_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              pause_i;
  logic              flush_i;
  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_ready_i;
  logic [1:0]        occ_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  // Producer/consumer side driving the stage.
  modport master (
    output pause_i, flush_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, occ_o, stall_cnt_o
  );

  // The stage itself.
  modport slave (
    input  pause_i, flush_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, occ_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter used for back-pressure statistics.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q;

  // Count up on inc, stick at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage with optional two-entry skid buffer, pause/flush control and stall counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  pipe_skid_reg_if.slave bus
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q;
  logic              out_valid_q;
  logic              in_ready;
  logic              tin, tout;
  logic              load_skid;

  // Ready: with a skid entry it depends only on registered state, otherwise it passes out_ready.
  always_comb begin
    if (SKID != 0) begin
      in_ready = ~bus.pause_i & (state_q != StFull);
    end else begin
      in_ready = ~bus.pause_i & (~out_valid_q | bus.out_ready_i);
    end
  end

  assign tin  = bus.in_valid_i & in_ready;
  assign tout = out_valid_q & bus.out_ready_i & ~bus.pause_i;

  // Next-state and head selection; flush wins over pause.
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    load_skid = 1'b0;
    if (bus.flush_i) begin
      state_d = StEmpty;
      head_d  = '0;
    end else if (!bus.pause_i) begin
      unique case (state_q)
        StEmpty: begin
          if (tin) begin
            state_d = StOne;
            head_d  = bus.in_data_i;
          end
        end
        StOne: begin
          if (tin && tout) begin
            head_d = bus.in_data_i;
          end else if (tin && (SKID != 0)) begin
            state_d   = StFull;
            load_skid = 1'b1;
          end else if (tout) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (tout) begin
            state_d = StOne;
            head_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State, head and registered valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StEmpty;
      head_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      out_valid_q <= (state_d != StEmpty);
    end
  end

  if (SKID != 0) begin : g_skid
    logic [DATA_W-1:0] skid_reg_q;

    // Second entry, captured only when the head is stalled and a new beat arrives.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        skid_reg_q <= '0;
      end else if (bus.flush_i) begin
        skid_reg_q <= '0;
      end else if (load_skid) begin
        skid_reg_q <= bus.in_data_i;
      end
    end

    assign skid_q = skid_reg_q;
  end else begin : g_no_skid
    assign skid_q = '0;
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc  (out_valid_q & ~bus.out_ready_i & ~bus.pause_i),
    .count(bus.stall_cnt_o)
  );

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = head_q;
  assign bus.occ_o       = occ_of(state_q);
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, corner-case sequences, randomized model check.
module tb_pipe_skid_reg;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pause = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.DATA_W(DW), .CNT_W(16)) bus_a ();
  pipe_skid_reg_if #(.DATA_W(DW), .CNT_W(4))  bus_b ();

  assign bus_a.pause_i     = pause;
  assign bus_a.flush_i     = flush;
  assign bus_a.in_valid_i  = in_valid;
  assign bus_a.in_data_i   = in_data;
  assign bus_a.out_ready_i = out_ready;
  assign bus_b.pause_i     = pause;
  assign bus_b.flush_i     = flush;
  assign bus_b.in_valid_i  = in_valid;
  assign bus_b.in_data_i   = in_data;
  assign bus_b.out_ready_i = out_ready;

  // A: skid buffer, wide counter. B: single register, 4-bit counter.
  pipe_skid_reg #(.DATA_W(DW), .SKID(1), .CNT_W(16)) u_a (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus_a)
  );

  pipe_skid_reg #(.DATA_W(DW), .SKID(0), .CNT_W(4)) u_b (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus_b)
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          r;
    logic          e_rdy;
    logic          e_ov;
    logic          e_chkd;
    logic [DW-1:0] e_d;
    logic [1:0]    e_occ;
    int unsigned   e_cnt;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic r,
                              input logic e_rdy, input logic e_ov, input logic e_chkd,
                              input logic [DW-1:0] e_d, input logic [1:0] e_occ,
                              input int unsigned e_cnt);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_chkd = e_chkd;
    t.e_d = e_d; t.e_occ = e_occ; t.e_cnt = e_cnt;
    return t;
  endfunction

  // what: 0 in_ready, 1 out_valid, 2 out_data, 3 occ, 4 stall count
  function automatic logic [31:0] dut_val(input int sel, input int what);
    logic [31:0] r;
    r = '0;
    if (sel == 0) begin
      case (what)
        0: r = 32'(bus_a.in_ready_o);
        1: r = 32'(bus_a.out_valid_o);
        2: r = 32'(bus_a.out_data_o);
        3: r = 32'(bus_a.occ_o);
        default: r = 32'(bus_a.stall_cnt_o);
      endcase
    end else begin
      case (what)
        0: r = 32'(bus_b.in_ready_o);
        1: r = 32'(bus_b.out_valid_o);
        2: r = 32'(bus_b.out_data_o);
        3: r = 32'(bus_b.occ_o);
        default: r = 32'(bus_b.stall_cnt_o);
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs away from the rising edge; outputs are sampled 1 ns later.
  task automatic drive(input logic p, input logic f, input logic v, input logic [DW-1:0] d,
                       input logic r);
    @(negedge clk);
    pause = p; flush = f; in_valid = v; in_data = d; out_ready = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pause = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Reference: an ordered list of held payloads plus a saturating count.
  task automatic run_random(input int sel, input int n);
    logic [DW-1:0] q[$];
    int unsigned   cnt;
    int unsigned   cmax;
    bit            skid;
    cnt  = 0;
    cmax = (sel == 0) ? 32'd65535 : 32'd15;
    skid = (sel == 0);
    for (int i = 0; i < n; i++) begin
      logic          p, f, v, r, e_rdy;
      logic [DW-1:0] d;
      bit            tin, tout;
      p = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < 6);
      d = DW'($urandom_range(0, 255));
      drive(p, f, v, d, r);
      e_rdy = !p && (skid ? (q.size() < 2) : (q.size() == 0 || r));
      chk("rnd_in_ready", dut_val(sel, 0), 32'(e_rdy));
      chk("rnd_out_valid", dut_val(sel, 1), 32'(q.size() != 0));
      chk("rnd_occ", dut_val(sel, 3), 32'(q.size()));
      chk("rnd_stall_cnt", dut_val(sel, 4), cnt);
      if (q.size() != 0) chk("rnd_out_data", dut_val(sel, 2), 32'(q[0]));
      tout = (q.size() != 0) && r && !p;
      tin  = v && e_rdy;
      if ((q.size() != 0) && !r && !p && (cnt < cmax)) cnt++;
      if (f) begin
        q.delete();
      end else begin
        if (tout) void'(q.pop_front());
        if (tin) q.push_back(d);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1'b1, 8'hA1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 0);
    tbl[1]  = mk(1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 2'd1, 0);
    tbl[2]  = mk(1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA2, 2'd1, 0);
    tbl[3]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 2'd1, 0);
    tbl[4]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 0);
    tbl[5]  = mk(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 0);
    tbl[6]  = mk(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1, 0);
    tbl[7]  = mk(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2, 1);
    tbl[8]  = mk(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2, 2);
    tbl[9]  = mk(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2, 3);
    tbl[10] = mk(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1, 3);
    tbl[11] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 2'd1, 3);
    tbl[12] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 3);

    // Reset state
    do_reset();
    chk("rst_in_ready", dut_val(0, 0), 32'd1);
    chk("rst_out_valid", dut_val(0, 1), 32'd0);
    chk("rst_out_data", dut_val(0, 2), 32'd0);
    chk("rst_occ", dut_val(0, 3), 32'd0);
    chk("rst_stall", dut_val(0, 4), 32'd0);
    pause = 1'b1;
    #1;
    chk("rst_in_ready_paused", dut_val(0, 0), 32'd0);
    chk("rst_in_ready_paused_b", dut_val(1, 0), 32'd0);
    pause = 1'b0;

    // Back-to-back streaming, then stall/fill/drain on the skid variant
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, 1'b0, tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_in_ready", i), dut_val(0, 0), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_out_valid", i), dut_val(0, 1), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_occ", i), dut_val(0, 3), 32'(tbl[i].e_occ));
      chk($sformatf("tbl%0d_stall", i), dut_val(0, 4), tbl[i].e_cnt);
      if (tbl[i].e_chkd) chk($sformatf("tbl%0d_out_data", i), dut_val(0, 2), 32'(tbl[i].e_d));
    end

    // Pause while full: nothing moves, counter frozen
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 8'h44, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h45, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 8'h46, 1'b1);
      chk("pause_occ", dut_val(0, 3), 32'd2);
      chk("pause_out_valid", dut_val(0, 1), 32'd1);
      chk("pause_out_data", dut_val(0, 2), 32'h44);
      chk("pause_in_ready", dut_val(0, 0), 32'd0);
      chk("pause_stall", dut_val(0, 4), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("post_pause_occ", dut_val(0, 3), 32'd2);
    chk("post_pause_stall", dut_val(0, 4), 32'd1);

    // Flush while full with a concurrent input beat
    drive(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
    chk("pre_flush_occ", dut_val(0, 3), 32'd2);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("flush_occ", dut_val(0, 3), 32'd0);
    chk("flush_out_valid", dut_val(0, 1), 32'd0);
    chk("flush_out_data", dut_val(0, 2), 32'd0);
    chk("flush_stall", dut_val(0, 4), 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("flush_no_emit", dut_val(0, 1), 32'd0);
    end

    // Flush overrides pause
    drive(1'b0, 1'b0, 1'b1, 8'h66, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 8'h67, 1'b1);
    chk("flushpause_pre_occ", dut_val(0, 3), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("flushpause_occ", dut_val(0, 3), 32'd0);
    chk("flushpause_out_valid", dut_val(0, 1), 32'd0);

    // Asynchronous reset mid-cycle while full
    drive(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h78, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("prereset_occ", dut_val(0, 3), 32'd2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", dut_val(0, 1), 32'd0);
    chk("async_rst_out_data", dut_val(0, 2), 32'd0);
    chk("async_rst_occ", dut_val(0, 3), 32'd0);
    chk("async_rst_stall", dut_val(0, 4), 32'd0);
    chk("async_rst_in_ready", dut_val(0, 0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("post_rst_no_emit", dut_val(0, 1), 32'd0);
    end

    // Saturation of the 4-bit counter on the single-register variant
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 8'h9C, 1'b0);
    chk("sat_load_out_valid", dut_val(1, 1), 32'd0);
    for (int k = 0; k < 21; k++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("sat_stall", dut_val(1, 4), (k < 15) ? 32'(k) : 32'd15);
      if (k == 0) begin
        chk("noskid_in_ready_blocked", dut_val(1, 0), 32'd0);
        chk("noskid_out_data", dut_val(1, 2), 32'h9C);
      end
    end
    out_ready = 1'b1;
    #1;
    chk("noskid_in_ready_pass", dut_val(1, 0), 32'd1);

    // Randomized runs against the reference model
    do_reset();
    run_random(0, 2000);
    do_reset();
    run_random(1, 2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter SKID, default 1; 1 = two-entry skid buffer, 0 = single-entry register.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port pause_i  input  1  hold: freeze all state and block transfers.
REQ-007 SHALL have port flush_i  input  1  synchronous kill of all held entries.
REQ-008 SHALL have port in_valid_i  input  1  upstream payload valid.
REQ-009 SHALL have port in_data_i  input  DATA_W  upstream payload.
REQ-010 SHALL have port in_ready_o  output  1  stage can accept this cycle.
REQ-011 SHALL have port out_valid_o  output  1  downstream payload valid.
REQ-012 SHALL have port out_data_o  output  DATA_W  downstream payload, always driven from the head entry.
REQ-013 SHALL have port out_ready_i  input  1  downstream accepts.
REQ-014 SHALL have port occ_o  output  2  entries held (0..2).
REQ-015 SHALL have port stall_cnt_o  output  CNT_W  saturating back-pressure counter.

Function
REQ-016 SHALL define transfer-in = in_valid_i & in_ready_o; transfer-out = out_valid_o & out_ready_i & ~pause_i.
REQ-017 SHALL implement states EMPTY (occ 0), ONE (head valid), FULL (head+skid valid, SKID=1 only).
REQ-018 SHALL, with SKID=1, drive in_ready_o = ~pause_i & (state != FULL), registered-state-derived, no combinational path from out_ready_i.
REQ-019 SHALL, with SKID=0, drive in_ready_o = ~pause_i & (~out_valid_o | out_ready_i).
REQ-020 SHALL transition EMPTY->ONE on transfer-in, loading head.
REQ-021 SHALL, in ONE: transfer-in & transfer-out -> ONE, head = in_data_i; transfer-in only -> FULL, skid = in_data_i (SKID=1); transfer-out only -> EMPTY.
REQ-022 SHALL, in FULL: on transfer-out move skid to head -> ONE; no transfer-in possible.
REQ-023 SHALL deliver each accepted payload exactly once, in order, latency one cycle from transfer-in to out_valid_o when EMPTY.
REQ-024 SHALL hold out_data_o stable while out_valid_o=1 and no transfer-out.
REQ-025 SHALL, when pause_i=1, keep state, head, skid and occ unchanged and perform no transfer.
REQ-026 SHALL, when flush_i=1, go to EMPTY next cycle, clear head and skid data to 0, discard any same-cycle transfer-in; flush has priority over pause_i.
REQ-027 SHALL drive occ_o = 0/1/2 for EMPTY/ONE/FULL.
REQ-028 SHALL increment stall_cnt_o each cycle with out_valid_o=1 & out_ready_i=0 & pause_i=0, saturating at all-ones; unaffected by flush_i.
REQ-029 SHALL treat out_valid_o, out_data_o, occ_o as registered outputs.

Reset
REQ-030 SHALL on rst_i force state EMPTY, out_valid_o=0, out_data_o=0, skid data=0, occ_o=0, stall_cnt_o=0; in_ready_o then equals ~pause_i.
REQ-031 SHALL abandon any in-flight entries on reset mid-operation without emitting them after release.

Structure
REQ-032 SHALL place state encoding (EMPTY=0, ONE=1, FULL=2) in shared package pipe_pkg.
REQ-033 SHALL be self-contained; natural sub-module is sat_counter (width CNT_W, inc, saturate) for stall_cnt_o.
REQ-034 SHALL elaborate no skid register when SKID=0.

Verification
REQ-035 SHALL cover: SKID=1, send 0xA1,0xA2,0xA3 back-to-back with out_ready_i=1 -> outputs 0xA1,0xA2,0xA3 on consecutive cycles, occ_o=1 throughout.
REQ-036 SHALL cover: SKID=1, out_ready_i=0, send 0x11,0x22,0x33 -> occ_o 1 then 2, in_ready_o=0 after second, 0x33 held upstream; release -> 0x11,0x22,0x33 in order.
REQ-037 SHALL cover: FULL with pause_i=1 for 5 cycles and out_ready_i=1 -> no transfer, occ_o=2, stall_cnt_o unchanged.
REQ-038 SHALL cover: FULL, flush_i=1 with in_valid_i=1 data 0x55 -> next cycle occ_o=0, out_valid_o=0, 0x55 never emitted.
REQ-039 SHALL cover: CNT_W=4, out_ready_i=0 for 20 cycles with valid head -> stall_cnt_o saturates at 15.
REQ-040 SHALL cover: rst_i asserted mid-cycle while FULL -> all outputs 0 immediately, no stale payload after release.
